// File: rtl/mips_multicycle_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control path: opcodes, FSM states,
// datapath select codes and the packed control word.
package mips_multicycle_ctrl_pkg;

  localparam int unsigned OP_W    = 6;
  localparam int unsigned STATE_W = 4;

  typedef enum logic [STATE_W-1:0] {
    S_RESET   = 4'd0,
    S_FETCH   = 4'd1,
    S_DECODE  = 4'd2,
    S_MEMADR  = 4'd3,
    S_MEMRD   = 4'd4,
    S_MEMWR   = 4'd5,
    S_MEMWB   = 4'd6,
    S_EXEC    = 4'd7,
    S_ALUWB   = 4'd8,
    S_IEXEC_S = 4'd9,
    S_IEXEC_Z = 4'd10,
    S_IWB     = 4'd11,
    S_BRANCH  = 4'd12,
    S_JUMP    = 4'd13
  } state_e;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OP_W-1:0] OP_BNE   = 6'b000101;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OP_W-1:0] OP_ANDI  = 6'b001100;
  localparam logic [OP_W-1:0] OP_ORI   = 6'b001101;
  localparam logic [OP_W-1:0] OP_SLTI  = 6'b001010;
  localparam logic [OP_W-1:0] OP_J     = 6'b000010;

  localparam logic [2:0] SRCB_B        = 3'b000;
  localparam logic [2:0] SRCB_FOUR     = 3'b001;
  localparam logic [2:0] SRCB_SEXT     = 3'b010;
  localparam logic [2:0] SRCB_SEXT_SH2 = 3'b011;
  localparam logic [2:0] SRCB_ZEXT     = 3'b100;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_OPC   = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       mem_write;
    logic       ir_write;
    logic       iord;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [2:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       pc_write;
    logic       pc_write_cond;
    logic       branch_ne;
    logic       illegal_op;
    logic       instr_done;
  } ctrl_t;

  function automatic logic op_is_legal(input logic [OP_W-1:0] op);
    case (op)
      OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE,
      OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI, OP_J: return 1'b1;
      default:                                 return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mips_multicycle_ctrl_outdec.sv
// Combinational state -> control word decode. Handshake-dependent terms are
// emitted ungated here; the top qualifies them with mem_ready.
module mips_ctrl_outdec
  import mips_multicycle_ctrl_pkg::*;
(
  input  state_e          state_i,
  input  logic [OP_W-1:0] op_i,
  output ctrl_t           ctrl_o
);

  always_comb begin
    ctrl_o = '0;
    case (state_i)
      S_FETCH: begin
        ctrl_o.alu_src_b = SRCB_FOUR;
        ctrl_o.ir_write  = 1'b1;
        ctrl_o.pc_write  = 1'b1;
      end
      S_DECODE: begin
        ctrl_o.alu_src_b  = SRCB_SEXT_SH2;
        ctrl_o.illegal_op = ~op_is_legal(op_i);
      end
      S_MEMADR: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_SEXT;
      end
      S_MEMRD: ctrl_o.iord = 1'b1;
      S_MEMWR: begin
        ctrl_o.iord       = 1'b1;
        ctrl_o.mem_write  = 1'b1;
        ctrl_o.instr_done = 1'b1;
      end
      S_MEMWB: begin
        ctrl_o.mem_to_reg = 1'b1;
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.instr_done = 1'b1;
      end
      S_EXEC: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_B;
        ctrl_o.alu_op    = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        ctrl_o.reg_dst    = 1'b1;
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.instr_done = 1'b1;
      end
      S_IEXEC_S, S_IEXEC_Z: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_op    = ALUOP_OPC;
        ctrl_o.alu_src_b = (state_i == S_IEXEC_Z) ? SRCB_ZEXT : SRCB_SEXT;
      end
      S_IWB: begin
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.instr_done = 1'b1;
      end
      S_BRANCH: begin
        ctrl_o.alu_src_a     = 1'b1;
        ctrl_o.alu_src_b     = SRCB_B;
        ctrl_o.alu_op        = ALUOP_SUB;
        ctrl_o.pc_write_cond = 1'b1;
        ctrl_o.pc_source     = PCSRC_ALUOUT;
        ctrl_o.branch_ne     = (op_i == OP_BNE);
        ctrl_o.instr_done    = 1'b1;
      end
      S_JUMP: begin
        ctrl_o.pc_source  = PCSRC_JUMP;
        ctrl_o.pc_write   = 1'b1;
        ctrl_o.instr_done = 1'b1;
      end
      default: ctrl_o = '0;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Main control FSM of the multicycle MIPS core: one instruction phase per
// state, with memory wait states, illegal-opcode flag and retire pulse.
module mips_multicycle_ctrl
  import mips_multicycle_ctrl_pkg::*;
#(
  parameter int unsigned OPW = 6,
  parameter int unsigned SW  = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [OPW-1:0] OP_code,
  input  logic           mem_ready,
  output logic           MemWrite,
  output logic           IRWrite,
  output logic           IorD,
  output logic           MemtoReg,
  output logic           RegDst,
  output logic           RegWrite,
  output logic           ALUSrcA,
  output logic [2:0]     ALUSrcB,
  output logic [1:0]     ALUOp,
  output logic [1:0]     PCSource,
  output logic           PCWrite,
  output logic           PCWriteCond,
  output logic           BranchNE,
  output logic           illegal_op,
  output logic           instr_done
);

  logic [SW-1:0] state_q, state_d;
  logic          store_q, store_d;
  state_e        state;
  ctrl_t         dec_ctrl, ctrl;

  // Raw register viewed through the enum so spare encodings fall to default arms.
  assign state = state_e'(state_q);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_RESET;
      store_q <= 1'b0;
    end else begin
      state_q <= state_d;
      store_q <= store_d;
    end
  end

  // lw/sw split is captured in DECODE so MEMADR does not re-read the opcode.
  always_comb begin
    state_d = S_FETCH;
    store_d = store_q;
    case (state)
      S_RESET:  state_d = S_FETCH;
      S_FETCH:  state_d = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        store_d = (OP_code == OP_SW);
        case (OP_code)
          OP_LW, OP_SW:     state_d = S_MEMADR;
          OP_RTYPE:         state_d = S_EXEC;
          OP_BEQ, OP_BNE:   state_d = S_BRANCH;
          OP_ADDI, OP_SLTI: state_d = S_IEXEC_S;
          OP_ANDI, OP_ORI:  state_d = S_IEXEC_Z;
          OP_J:             state_d = S_JUMP;
          default:          state_d = S_FETCH;
        endcase
      end
      S_MEMADR:             state_d = store_q ? S_MEMWR : S_MEMRD;
      S_MEMRD:              state_d = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWR:              state_d = mem_ready ? S_FETCH : S_MEMWR;
      S_EXEC:               state_d = S_ALUWB;
      S_IEXEC_S, S_IEXEC_Z: state_d = S_IWB;
      default:              state_d = S_FETCH;
    endcase
  end

  mips_ctrl_outdec u_outdec (
    .state_i (state),
    .op_i    (OP_code),
    .ctrl_o  (dec_ctrl)
  );

  always_comb begin
    ctrl = dec_ctrl;
    if (state == S_FETCH) begin
      ctrl.ir_write = dec_ctrl.ir_write & mem_ready;
      ctrl.pc_write = dec_ctrl.pc_write & mem_ready;
    end
    if (state == S_MEMWR) begin
      ctrl.instr_done = dec_ctrl.instr_done & mem_ready;
    end
  end

  assign MemWrite    = ctrl.mem_write;
  assign IRWrite     = ctrl.ir_write;
  assign IorD        = ctrl.iord;
  assign MemtoReg    = ctrl.mem_to_reg;
  assign RegDst      = ctrl.reg_dst;
  assign RegWrite    = ctrl.reg_write;
  assign ALUSrcA     = ctrl.alu_src_a;
  assign ALUSrcB     = ctrl.alu_src_b;
  assign ALUOp       = ctrl.alu_op;
  assign PCSource    = ctrl.pc_source;
  assign PCWrite     = ctrl.pc_write;
  assign PCWriteCond = ctrl.pc_write_cond;
  assign BranchNE    = ctrl.branch_ne;
  assign illegal_op  = ctrl.illegal_op;
  assign instr_done  = ctrl.instr_done;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Bench for mips_multicycle_ctrl: per instruction, a list of expected phase
// words is built from the opcode table and replayed against the DUT.
module tb_mips_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] OP_code;
  logic       mem_ready;
  logic       MemWrite, IRWrite, IorD, MemtoReg, RegDst, RegWrite, ALUSrcA;
  logic [2:0] ALUSrcB;
  logic [1:0] ALUOp, PCSource;
  logic       PCWrite, PCWriteCond, BranchNE, illegal_op, instr_done;

  always #5 clk = ~clk;

  mips_multicycle_ctrl #(.OPW(6), .SW(4)) dut (
    .clk(clk), .rst(rst), .OP_code(OP_code), .mem_ready(mem_ready),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .IorD(IorD), .MemtoReg(MemtoReg),
    .RegDst(RegDst), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ALUOp(ALUOp), .PCSource(PCSource), .PCWrite(PCWrite),
    .PCWriteCond(PCWriteCond), .BranchNE(BranchNE), .illegal_op(illegal_op),
    .instr_done(instr_done)
  );

  int unsigned checks = 0;
  int unsigned errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [18:0] obs();
    return {MemWrite, IRWrite, IorD, MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB,
            ALUOp, PCSource, PCWrite, PCWriteCond, BranchNE, illegal_op, instr_done};
  endfunction

  function automatic logic [18:0] cw(
    input bit mw, ir, iord, m2r, rdst, rw, asa, input logic [2:0] asb,
    input logic [1:0] aop, pcs, input bit pcw, pcc, bne, ill, done);
    return {mw, ir, iord, m2r, rdst, rw, asa, asb, aop, pcs, pcw, pcc, bne, ill, done};
  endfunction

  // base: fixed outputs; gate: outputs that equal mem_ready; wt: phase waits on mem_ready
  typedef struct {
    logic [18:0] base;
    logic [18:0] gate;
    bit          wt;
  } phase_t;

  phase_t plan[$];
  int     mr_script[$];
  int     zero_run = 0;

  task automatic add(input logic [18:0] base, input logic [18:0] gate, input bit wt);
    phase_t p;
    p.base = base; p.gate = gate; p.wt = wt;
    plan.push_back(p);
  endtask

  task automatic build_plan(input logic [5:0] op);
    bit legal;
    legal = op inside {6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000101,
                       6'b001000, 6'b001100, 6'b001101, 6'b001010, 6'b000010};
    plan.delete();
    //      mw ir io mr rd rw sa  srcB    aop    pcs   pw pc bn il dn
    add(cw(0, 0, 0, 0, 0, 0, 0, 3'b001, 2'b00, 2'b00, 0, 0, 0, 0, 0),
        cw(0, 1, 0, 0, 0, 0, 0, 3'b000, 2'b00, 2'b00, 1, 0, 0, 0, 0), 1);
    add(cw(0, 0, 0, 0, 0, 0, 0, 3'b011, 2'b00, 2'b00, 0, 0, 0, !legal, 0), '0, 0);
    case (op)
      6'b100011: begin
        add(cw(0, 0, 0, 0, 0, 0, 1, 3'b010, 2'b00, 2'b00, 0, 0, 0, 0, 0), '0, 0);
        add(cw(0, 0, 1, 0, 0, 0, 0, 3'b000, 2'b00, 2'b00, 0, 0, 0, 0, 0), '0, 1);
        add(cw(0, 0, 0, 1, 0, 1, 0, 3'b000, 2'b00, 2'b00, 0, 0, 0, 0, 1), '0, 0);
      end
      6'b101011: begin
        add(cw(0, 0, 0, 0, 0, 0, 1, 3'b010, 2'b00, 2'b00, 0, 0, 0, 0, 0), '0, 0);
        add(cw(1, 0, 1, 0, 0, 0, 0, 3'b000, 2'b00, 2'b00, 0, 0, 0, 0, 0),
            cw(0, 0, 0, 0, 0, 0, 0, 3'b000, 2'b00, 2'b00, 0, 0, 0, 0, 1), 1);
      end
      6'b000000: begin
        add(cw(0, 0, 0, 0, 0, 0, 1, 3'b000, 2'b10, 2'b00, 0, 0, 0, 0, 0), '0, 0);
        add(cw(0, 0, 0, 0, 1, 1, 0, 3'b000, 2'b00, 2'b00, 0, 0, 0, 0, 1), '0, 0);
      end
      6'b001000, 6'b001010, 6'b001100, 6'b001101: begin
        add(cw(0, 0, 0, 0, 0, 0, 1, (op[2] ? 3'b100 : 3'b010), 2'b11, 2'b00, 0, 0, 0, 0, 0),
            '0, 0);
        add(cw(0, 0, 0, 0, 0, 1, 0, 3'b000, 2'b00, 2'b00, 0, 0, 0, 0, 1), '0, 0);
      end
      6'b000100, 6'b000101:
        add(cw(0, 0, 0, 0, 0, 0, 1, 3'b000, 2'b01, 2'b01, 0, 1, (op == 6'b000101), 0, 1),
            '0, 0);
      6'b000010:
        add(cw(0, 0, 0, 0, 0, 0, 0, 3'b000, 2'b00, 2'b10, 1, 0, 0, 0, 1), '0, 0);
      default: ;
    endcase
  endtask

  task automatic next_mr(output logic v);
    if (mr_script.size() > 0) v = mr_script.pop_front() != 0;
    else if (zero_run >= 5)   v = 1'b1;
    else                      v = ($urandom_range(0, 3) != 0);
    zero_run = v ? 0 : zero_run + 1;
  endtask

  // abort_after > 0: assert reset after that many checked cycles of the instruction
  task automatic run_instr(input logic [5:0] op, input string name, input int abort_after);
    logic        mr;
    logic [18:0] exp;
    int          n = 0;
    build_plan(op);
    for (int i = 0; i < plan.size(); i++) begin
      do begin
        @(negedge clk);
        OP_code = op;
        next_mr(mr);
        mem_ready = mr;
        #1;
        exp = plan[i].base | (plan[i].gate & {19{mr}});
        check($sformatf("%s.p%0d", name, i), 32'(obs()), 32'(exp));
        n++;
        if (n == abort_after) begin
          check({name, ".pre_rst.MemWrite"}, 32'(MemWrite), 32'd1);
          rst = 1'b0;
          #1;
          check({name, ".rst.MemWrite"}, 32'(MemWrite), 32'd0);
          check({name, ".rst.outs"}, 32'(obs()), 32'd0);
          return;
        end
      end while (plan[i].wt && !mr);
    end
  endtask

  task automatic reset_release();
    @(negedge clk);
    mem_ready = 1'b1;
    #1;
    check("rst_held.outs", 32'(obs()), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("s_reset.outs", 32'(obs()), 32'd0);
  endtask

  logic [5:0] op_tab [10] = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000101,
                              6'b001000, 6'b001100, 6'b001101, 6'b001010, 6'b000010};

  initial begin
    logic [5:0] op;
    rst = 1'b0;
    OP_code = '0;
    mem_ready = 1'b0;
    #3;
    check("reset.outs", 32'(obs()), 32'd0);
    reset_release();

    mr_script = '{1, 1, 1, 1, 1};
    run_instr(6'b100011, "lw", 0);
    mr_script = '{0, 0, 0, 1, 1, 1, 1};
    run_instr(6'b000000, "fetch_wait", 0);
    mr_script = '{1, 1, 1, 0, 0, 1};
    run_instr(6'b101011, "sw_wait", 0);
    mr_script = '{1, 1, 1};
    run_instr(6'b000101, "bne", 0);
    mr_script = '{1, 1, 1};
    run_instr(6'b000100, "beq", 0);
    mr_script = '{1, 1};
    run_instr(6'b111111, "illegal", 0);
    mr_script = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 1};
    run_instr(6'b000010, "j", 0);
    run_instr(6'b001000, "addi", 0);
    run_instr(6'b001101, "ori", 0);

    for (int k = 0; k < 300; k++) begin
      if ($urandom_range(0, 3) == 0) op = 6'($urandom);
      else                           op = op_tab[$urandom_range(0, 9)];
      run_instr(op, $sformatf("rnd%0d_op%b", k, op), 0);
    end

    mr_script = '{1, 1, 1, 0};
    run_instr(6'b101011, "rst_memwr", 4);
    reset_release();
    for (int k = 0; k < 20; k++) begin
      op = op_tab[$urandom_range(0, 9)];
      run_instr(op, $sformatf("post_rst%0d", k), 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
